// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: data/op widths, ALU op codes
// and the sequencer state encoding.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int SHAMT_W = 5;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'b0100;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'b0110;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'b0111;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'b1000;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'b1001;
  localparam logic [OP_W-1:0] ALU_LUI  = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit integer ALU. Shift amounts use the whole B operand, so
// any B of 32 or more shifts everything out and yields zero.
module alu_core
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y
);

  logic               w_big_shift;
  logic [SHAMT_W-1:0] w_shamt;

  assign w_big_shift = |i_b[DATA_W-1:SHAMT_W];
  assign w_shamt     = i_b[SHAMT_W-1:0];

  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD:  o_y = i_a + i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_AND:  o_y = i_a & i_b;
      ALU_OR:   o_y = i_a | i_b;
      ALU_SLL:  o_y = w_big_shift ? '0 : (i_a << w_shamt);
      ALU_SRL:  o_y = w_big_shift ? '0 : (i_a >> w_shamt);
      ALU_SRA:  o_y = w_big_shift ? '0 : $unsigned($signed(i_a) >>> w_shamt);
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_SLT:  o_y = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_y = {{(DATA_W-1){1'b0}}, (i_a < i_b)};
      ALU_LUI:  o_y = i_b;
      default:  o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_pick.sv
// Two-way round-robin grant: a lone requester always wins; on contention the
// port that did not win last time is granted.
module alu_rr_pick (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last,
  output logic o_gnt0,
  output logic o_gnt1
);

  assign o_gnt0 = i_valid0 & (~i_valid1 | i_last);
  assign o_gnt1 = i_valid1 & (~i_valid0 | ~i_last);

endmodule

// File: rtl/alu_share_arb.sv
// Arbiter/sequencer sharing one ALU between two requesters: one op in flight,
// IDLE -> EXEC -> RESP, result returned to the port that issued it.
module alu_share_arb
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output state_t            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high. reqN_ready depends combinationally on the valids (grant), never
  // the reverse; rspN_valid is registered and independent of rspN_ready.

  state_t            r_state;
  logic              r_last;
  logic              r_owner;
  logic              r_rsp0_valid;
  logic              r_rsp1_valid;
  logic              r_busy;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_rsp_data;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_idle;
  logic              w_acc0;
  logic              w_acc1;
  logic              w_rsp_hs;
  logic [DATA_W-1:0] w_alu_y;

  alu_rr_pick u_pick (
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .i_last   (r_last),
    .o_gnt0   (w_gnt0),
    .o_gnt1   (w_gnt1)
  );

  alu_core u_alu (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_alu_y)
  );

  // rst_n gates ready so nothing looks accepted while reset is held.
  assign w_idle     = (r_state == S_IDLE);
  assign req0_ready = rst_n & w_idle & w_gnt0;
  assign req1_ready = rst_n & w_idle & w_gnt1;
  assign w_acc0     = req0_valid & req0_ready;
  assign w_acc1     = req1_valid & req1_ready;

  // Only the owner's ready can complete the response.
  assign w_rsp_hs = (r_rsp0_valid & rsp0_ready) | (r_rsp1_valid & rsp1_ready);

  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp_data   = r_rsp_data;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last       <= 1'b1;
      r_owner      <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc0 || w_acc1) begin
            r_op    <= w_acc1 ? req1_op : req0_op;
            r_a     <= w_acc1 ? req1_a  : req0_a;
            r_b     <= w_acc1 ? req1_b  : req0_b;
            r_owner <= w_acc1;
            r_last  <= w_acc1;
            r_busy  <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_data   <= w_alu_y;
          r_rsp0_valid <= ~r_owner;
          r_rsp1_valid <= r_owner;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_rsp0_valid <= 1'b0;
          r_rsp1_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed cases from the test plan plus randomized
// two-port traffic, checked by a scoreboard fed from a reference ALU model.
module tb_alu_share_arb;
  import alu_pkg::*;

  localparam int EW = 1 + 32 + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req0_valid = 1'b0;
  logic              req1_valid = 1'b0;
  logic [OP_W-1:0]   req0_op = '0;
  logic [OP_W-1:0]   req1_op = '0;
  logic [DATA_W-1:0] req0_a = '0;
  logic [DATA_W-1:0] req0_b = '0;
  logic [DATA_W-1:0] req1_a = '0;
  logic [DATA_W-1:0] req1_b = '0;
  logic              rsp0_ready = 1'b0;
  logic              rsp1_ready = 1'b0;
  logic              req0_ready;
  logic              req1_ready;
  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  state_t            dbg_state;

  alu_share_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic m_flight = 1'b0;
  logic m_last   = 1'b1;
  logic acc_hs;
  logic mon_hs;
  logic prev_valid = 1'b0;
  int   first_port = -1;
  int   rdy_mode   = 1;
  logic hold0      = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference ALU written from the op-code table.
  function automatic logic [DATA_W-1:0] ref_alu(input logic [OP_W-1:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    longint sa;
    longint sb;
    logic signed [DATA_W-1:0] s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = a;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return (b >= 32) ? '0 : (a << b);
      4'd5:    return (b >= 32) ? '0 : (a >> b);
      4'd6:    return (b >= 32) ? '0 : DATA_W'(s >>> b);
      4'd7:    return a ^ b;
      4'd8:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return b;
      default: return '0;
    endcase
  endfunction

  // ---------------- response ready driver ----------------
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 1) begin
      rsp0_ready = !hold0;
      rsp1_ready = 1'b1;
    end else begin
      rsp0_ready = !hold0 && ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- accept watcher: grant rules + expected push ----------------
  initial forever begin
    @(posedge clk);
    if (rst_n) begin
      acc_hs = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
      if (m_flight) begin
        check("ready_while_busy", {req0_ready, req1_ready}, 2'b00);
      end else if (req0_valid || req1_valid) begin
        if ((req0_valid && req1_valid) ? !m_last : req1_valid)
          check("grant", {req0_ready, req1_ready}, 2'b01);
        else
          check("grant", {req0_ready, req1_ready}, 2'b10);
      end
      if (req0_valid && req0_ready) begin
        exp_q.push_back({1'b0, 32'(cyc), ref_alu(req0_op, req0_a, req0_b)});
        m_flight = 1'b1;
        m_last   = 1'b0;
        if (first_port < 0) first_port = 0;
      end else if (req1_valid && req1_ready) begin
        exp_q.push_back({1'b1, 32'(cyc), ref_alu(req1_op, req1_a, req1_b)});
        m_flight = 1'b1;
        m_last   = 1'b1;
        if (first_port < 0) first_port = 1;
      end
      if (acc_hs) m_flight = 1'b0;
    end
    cyc++;
  end

  // ---------------- response monitor / scoreboard ----------------
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else if (rsp0_valid || rsp1_valid) begin
      mon_hs = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
      check("rsp_onehot", rsp0_valid & rsp1_valid, 0);
      check("busy_in_resp", busy, 1);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: port%0d data 0x%0h, no response expected", rsp1_valid, rsp_data);
      end else begin
        mon_e = exp_q[0];
        check("rsp_port", rsp1_valid, mon_e[EW-1]);
        check("rsp_data", rsp_data, mon_e[DATA_W-1:0]);
        if (!prev_valid)
          check("rsp_latency", cyc, 64'(mon_e[DATA_W+31:DATA_W]) + 2);
        if (mon_hs) void'(exp_q.pop_front());
      end
      prev_valid = !mon_hs;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input bit p, input logic [OP_W-1:0] op,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    int n = 0;
    @(posedge clk);
    #1;
    if (!p) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    forever begin
      @(posedge clk);
      if (p ? req1_ready : req0_ready) break;
      n++;
      if (n > 300) begin
        fail_now(p ? "req1_accept_timeout" : "req0_accept_timeout");
        break;
      end
    end
    #1;
    if (!p) req0_valid = 1'b0;
    else    req1_valid = 1'b0;
  endtask

  task automatic rand_issue(input bit p);
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    a = $urandom();
    b = ($urandom_range(0, 2) == 0) ? DATA_W'($urandom_range(0, 40)) : $urandom();
    issue(p, OP_W'($urandom_range(0, 15)), a, b);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || m_flight) && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) fail_now("wait_idle");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp0_valid"}, rsp0_valid, 0);
    check({tag, "_rsp1_valid"}, rsp1_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_req_ready"}, {req0_ready, req1_ready}, 2'b00);
    check({tag, "_state"}, 64'(dbg_state), 64'(S_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;

    // Lone request: add 5+7.
    issue(0, ALU_ADD, 32'd5, 32'd7);
    wait_idle();

    // Reset while the op is in EXEC: dropped, never answered.
    issue(0, ALU_ADD, 32'd100, 32'd200);
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    exp_q.delete();
    m_flight = 1'b0;
    m_last = 1'b1;
    first_port = -1;
    #1;
    check_reset_outputs("mid_exec_rst");
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;

    // Contention right after reset: port 0 first.
    fork
      issue(0, ALU_SUB, 32'd10, 32'd3);
      issue(1, ALU_XOR, 32'h0000_00F0, 32'h0000_00FF);
    join
    wait_idle();
    check("first_grant_after_reset", first_port, 0);

    // Both ports continuously valid: strict alternation.
    fork
      repeat (6) rand_issue(0);
      repeat (6) rand_issue(1);
    join
    wait_idle();

    // Signed vs unsigned compare.
    issue(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    issue(1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
    wait_idle();

    // Backpressure on port 0 while port 1 waits.
    hold0 = 1'b1;
    issue(0, ALU_OR, 32'hA5A5_0000, 32'h0000_5A5A);
    fork
      issue(1, ALU_ADD, 32'd1, 32'd2);
    join_none
    begin
      int n = 0;
      while (!rsp0_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) fail_now("bp_rsp0_valid_wait");
    end
    repeat (5) begin
      @(negedge clk);
      check("bp_rsp0_valid", rsp0_valid, 1);
      check("bp_rsp_data", rsp_data, 32'hA5A5_5A5A);
      check("bp_busy", busy, 1);
      check("bp_req1_ready", req1_ready, 0);
    end
    hold0 = 1'b0;
    wait fork;
    wait_idle();

    // Edge ops.
    issue(0, ALU_SLL, 32'd1, 32'd31);
    issue(0, ALU_SLL, 32'd1, 32'd32);
    issue(1, ALU_LUI, 32'hDEAD_BEEF, 32'h1234_5000);
    issue(0, 4'b1111, 32'd5, 32'd6);
    issue(1, ALU_SRA, 32'h8000_0000, 32'd40);
    wait_idle();

    // Randomized traffic with random response backpressure.
    rdy_mode = 0;
    fork
      repeat (60) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        rand_issue(0);
      end
      repeat (60) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        rand_issue(1);
      end
    join
    wait_idle();
    rdy_mode = 1;
    repeat (3) @(posedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
